// File: rtl/sprite_anim_rom.sv
// Sprite pixel ROM with a built-in animation frame sequencer.
// NUM_FRAMES frames of one SPR_W x SPR_H sprite are stored frame-major in a
// single memory. A lookup takes signed sprite-relative coordinates and returns
// a palette index and an opaque flag exactly two cycles later. Lookups are
// fully pipelined at one per cycle. Out-of-bounds or transparent pixels come
// back with pix_opaque low.
module sprite_anim_rom #(
   parameter int          DATA_W          = 4,
   parameter int          SPR_W           = 32,
   parameter int          SPR_H           = 32,
   parameter int          NUM_FRAMES      = 4,
   parameter int          TICKS_PER_FRAME = 8,
   parameter int          REL_W           = 11,
   parameter int          TRANSPARENT_IDX = 0,
   parameter string       INIT_FILE       = "./sprite/sprite.mif",
   localparam int         FRAME_W         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    vsync_tick,
   input  logic                    anim_en,
   input  logic                    anim_restart,
   input  logic                    flip_h,
   input  logic                    req_valid,
   input  logic signed [REL_W-1:0] rel_x,
   input  logic signed [REL_W-1:0] rel_y,
   output logic                    pix_valid,
   output logic [DATA_W-1:0]       pix_idx,
   output logic                    pix_opaque,
   output logic [FRAME_W-1:0]      cur_frame
);

   // ------------------------------------------------------------------
   // Derived sizes
   // ------------------------------------------------------------------
   localparam int DEPTH  = NUM_FRAMES * SPR_W * SPR_H;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam int X_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int Y_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   localparam logic [DATA_W-1:0]       TRANSP      = DATA_W'(TRANSPARENT_IDX);
   localparam logic signed [REL_W-1:0] SPR_W_REL   = REL_W'(SPR_W);
   localparam logic signed [REL_W-1:0] SPR_H_REL   = REL_W'(SPR_H);
   localparam logic [FRAME_W-1:0]      LAST_FRAME  = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [CNT_W-1:0]        LAST_TICK   = CNT_W'(TICKS_PER_FRAME - 1);
   localparam logic [ADDR_W-1:0]       FRAME_SIZE  = ADDR_W'(SPR_W * SPR_H);
   localparam logic [ADDR_W-1:0]       ROW_SIZE    = ADDR_W'(SPR_W);
   localparam logic [ADDR_W-1:0]       X_MAX       = ADDR_W'(SPR_W - 1);

   // ------------------------------------------------------------------
   // Sprite memory
   // ------------------------------------------------------------------
   // Contents come from INIT_FILE at synthesis. The zero initialiser only
   // gives simulation a defined starting value; nothing in this block ever
   // writes the array.
   (* ram_init_file = INIT_FILE *)
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic               s1_valid_q, s1_valid_d;
   logic               s1_inb_q,   s1_inb_d;
   logic [ADDR_W-1:0]  s1_addr_q,  s1_addr_d;

   logic               s2_valid_q, s2_valid_d;
   logic               s2_inb_q,   s2_inb_d;
   logic               live_q,     live_d;
   logic [DATA_W-1:0]  rd_data_q;

   // Stage-1 address arithmetic
   logic               x_ok, y_ok;
   logic [ADDR_W-1:0]  x_a, y_a, f_a;

   // Animation sequencer: restart beats ticks, ticks only count when enabled.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      frame_d = frame_q;
      cnt_d   = cnt_q;
      if (anim_restart) begin
         frame_d = '0;
         cnt_d   = '0;
      end else if (anim_en && vsync_tick) begin
         if (cnt_q == LAST_TICK) begin
            cnt_d   = '0;
            frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FRAME_W'(1);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Stage 1: bounds test, optional mirror and frame-major address.
   always_comb begin
      x_ok = !rel_x[REL_W-1] && (rel_x < SPR_W_REL);
      y_ok = !rel_y[REL_W-1] && (rel_y < SPR_H_REL);
      x_a  = ADDR_W'(rel_x[X_W-1:0]);
      y_a  = ADDR_W'(rel_y[Y_W-1:0]);
      f_a  = ADDR_W'(frame_q);
      if (flip_h) begin
         x_a = X_MAX - x_a;
      end
      s1_valid_d = req_valid;
      s1_inb_d   = x_ok && y_ok;
      // Out-of-bounds requests read word 0 rather than a wrapped address.
      s1_addr_d  = s1_inb_d ? (f_a * FRAME_SIZE + y_a * ROW_SIZE + x_a) : '0;
   end

   // Stage 2 control: in_bounds follows the read data and only moves with a
   // valid beat, so the outputs hold between responses.
   always_comb begin
      s2_valid_d = s1_valid_q;
      s2_inb_d   = s1_valid_q ? s1_inb_q : s2_inb_q;
      live_d     = live_q | s1_valid_q;
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (reset) begin
         frame_q    <= '0;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_inb_q   <= 1'b0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_inb_q   <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         frame_q    <= frame_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_inb_q   <= s1_inb_d;
         s1_addr_q  <= s1_addr_d;
         s2_valid_q <= s2_valid_d;
         s2_inb_q   <= s2_inb_d;
         live_q     <= live_d;
      end
   end

   // Registered memory read, enabled by the stage-1 valid.
   always_ff @(posedge clock) begin
      // NOTE: the read register carries no reset so it maps onto the block
      // RAM output register; live_q masks it until the first response.
      if (s1_valid_q) begin
         rd_data_q <= mem[s1_addr_q];
      end
   end

   // Output mapping: zero until the first response after reset, then the
   // read word or the transparent index for out-of-bounds lookups.
   always_comb begin
      pix_valid  = s2_valid_q;
      pix_idx    = '0;
      pix_opaque = 1'b0;
      if (live_q) begin
         pix_idx    = s2_inb_q ? rd_data_q : TRANSP;
         pix_opaque = s2_inb_q && (rd_data_q != TRANSP);
      end
      cur_frame = frame_q;
   end

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Scoreboard bench for sprite_anim_rom. Two instances share all stimulus:
// the default configuration, and DATA_W=3 / TRANSPARENT_IDX=7. The bench
// fills both memories with a known pattern, tracks the animation frame
// itself, and queues the expected response for every request issued.
module tb_sprite_anim_rom;

   localparam int REL_W = 11;
   localparam int SW    = 32;
   localparam int SH    = 32;
   localparam int NF    = 4;
   localparam int TPF   = 8;

   logic clock = 1'b0;
   logic reset, vsync_tick, anim_en, anim_restart, flip_h, req_valid;
   logic signed [REL_W-1:0] rel_x, rel_y;

   logic       pix_valid,  pix_opaque;
   logic [3:0] pix_idx;
   logic [1:0] cur_frame;
   logic       pix_valid7, pix_opaque7;
   logic [2:0] pix_idx7;
   logic [1:0] cur_frame7;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Bench-side model of the sequencer.
   int m_frame = 0;
   int m_cnt   = 0;

   typedef struct {
      int due;
      int idx;
      int op;
      int idx7;
      int op7;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   sprite_anim_rom dut (
      .clock(clock), .reset(reset), .vsync_tick(vsync_tick), .anim_en(anim_en),
      .anim_restart(anim_restart), .flip_h(flip_h), .req_valid(req_valid),
      .rel_x(rel_x), .rel_y(rel_y), .pix_valid(pix_valid), .pix_idx(pix_idx),
      .pix_opaque(pix_opaque), .cur_frame(cur_frame)
   );

   sprite_anim_rom #(.DATA_W(3), .TRANSPARENT_IDX(7)) dut7 (
      .clock(clock), .reset(reset), .vsync_tick(vsync_tick), .anim_en(anim_en),
      .anim_restart(anim_restart), .flip_h(flip_h), .req_valid(req_valid),
      .rel_x(rel_x), .rel_y(rel_y), .pix_valid(pix_valid7), .pix_idx(pix_idx7),
      .pix_opaque(pix_opaque7), .cur_frame(cur_frame7)
   );

   // Memory pattern: word 0 is 5, word 15 is 0.
   function automatic int mem_val(input int i);
      return (i * 5 + (i >> 5) * 3 + (i >> 10) * 7 + 5) & 15;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, update the model at the edge, check at
   // the falling edge.
   task automatic step(input logic rq, input int x, input int y, input logic fl,
                       input logic tk, input logic en, input logic rs, input logic rst);
      exp_t e;
      bit   inb;
      int   addr, v;
      reset        = rst;
      req_valid    = rq;
      rel_x        = REL_W'(x);
      rel_y        = REL_W'(y);
      flip_h       = fl;
      vsync_tick   = tk;
      anim_en      = en;
      anim_restart = rs;
      @(posedge clock);
      cyc++;
      if (rst) begin
         sb.delete();
         m_frame = 0;
         m_cnt   = 0;
      end else begin
         if (rq) begin
            inb  = (x >= 0) && (x < SW) && (y >= 0) && (y < SH);
            addr = m_frame * SW * SH + y * SW + (fl ? (SW - 1 - x) : x);
            v    = inb ? mem_val(addr) : 0;
            e.due  = cyc + 1;
            e.idx  = inb ? v : 0;
            e.op   = (inb && v != 0) ? 1 : 0;
            e.idx7 = inb ? (v & 7) : 7;
            e.op7  = (inb && (v & 7) != 7) ? 1 : 0;
            sb.push_back(e);
         end
         if (rs) begin
            m_frame = 0;
            m_cnt   = 0;
         end else if (en && tk) begin
            if (m_cnt == TPF - 1) begin
               m_cnt   = 0;
               m_frame = (m_frame == NF - 1) ? 0 : m_frame + 1;
            end else begin
               m_cnt++;
            end
         end
      end
      @(negedge clock);
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check("pix_valid", 32'(pix_valid), 1);
         check("pix_idx", 32'(pix_idx), e.idx);
         check("pix_opaque", 32'(pix_opaque), e.op);
         check("pix_valid7", 32'(pix_valid7), 1);
         check("pix_idx7", 32'(pix_idx7), e.idx7);
         check("pix_opaque7", 32'(pix_opaque7), e.op7);
      end else begin
         check("idle_valid", 32'(pix_valid), 0);
         check("idle_valid7", 32'(pix_valid7), 0);
      end
      if (rst) begin
         check("rst_idx", 32'(pix_idx), 0);
         check("rst_opaque", 32'(pix_opaque), 0);
         check("rst_idx7", 32'(pix_idx7), 0);
         check("rst_opaque7", 32'(pix_opaque7), 0);
      end
      check("cur_frame", 32'(cur_frame), m_frame);
      check("cur_frame7", 32'(cur_frame7), m_frame);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n, input logic en, input logic with_req);
      for (int i = 0; i < n; i++) begin
         step(with_req, int'($urandom_range(0, 39)) - 4, int'($urandom_range(0, 39)) - 4,
              1'($urandom_range(0, 1)), 1, en, 0, 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; rel_x = '0; rel_y = '0; flip_h = 1'b0;
      vsync_tick = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
      #1;
      for (int i = 0; i < NF * SW * SH; i++) begin
         dut.mem[i]  = 4'(mem_val(i));
         dut7.mem[i] = 3'(mem_val(i));
      end

      // Reset state
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // Single lookup, two-cycle latency, word 0
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(4);

      // Plain and mirrored addresses, out-of-bounds, transparent word
      step(1, 3, 2, 0, 0, 0, 0, 0);
      step(1, 3, 2, 1, 0, 0, 0, 0);
      step(1, -1, 0, 0, 0, 0, 0, 0);
      step(1, 32, 0, 0, 0, 0, 0, 0);
      step(1, 0, 32, 0, 0, 0, 0, 0);
      step(1, 0, -1, 1, 0, 0, 0, 0);
      step(1, 15, 0, 0, 0, 0, 0, 0);
      step(1, 31, 31, 1, 0, 0, 0, 0);
      idle(3);

      // Sequencer: advance after 8 ticks, wrap after 32, freeze when disabled
      ticks(8, 1, 1);
      ticks(24, 1, 1);
      ticks(3, 1, 1);
      ticks(6, 0, 1);
      ticks(5, 1, 1);
      ticks(4, 1, 0);
      idle(3);

      // Restart with a same-cycle tick and request at frame 2, count 7
      step(0, 0, 0, 0, 0, 0, 0, 1);
      ticks(16, 1, 0);
      ticks(7, 1, 0);
      step(1, 5, 5, 0, 1, 1, 1, 0);
      ticks(7, 1, 1);
      ticks(1, 1, 1);
      idle(3);

      // Back-to-back requests, reset lands on requests 3 and 4
      ticks(9, 1, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 2, 3, 1, 0, 0, 0, 0);
      step(1, 4, 5, 0, 0, 0, 0, 1);
      step(1, 6, 7, 1, 0, 0, 0, 1);
      idle(4);

      // Back-to-back stream without reset
      step(1, 10, 0, 0, 0, 0, 0, 0);
      step(1, 11, 1, 1, 0, 0, 0, 0);
      step(1, 12, 2, 0, 0, 0, 0, 0);
      step(1, 13, 3, 1, 0, 0, 0, 0);
      idle(4);

      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_anim_rom.md
Name: sprite_anim_rom

Overview:
- Parametrised sprite pixel ROM holding NUM_FRAMES animation frames of one SPR_W x SPR_H sprite, stored frame-major in a single synthesised memory initialised from INIT_FILE.
- Adds a built-in animation frame sequencer, horizontal mirroring and bounds/transparency detection.
- Sits between the per-pixel sprite-relative coordinate logic and the palette/colour mapper.
- Replaces the per-direction, per-frame fixed ROMs with one pipelined block per character.

Parameters:
DATA_W, 4, palette index width per pixel
SPR_W, 32, sprite width in pixels
SPR_H, 32, sprite height in pixels
NUM_FRAMES, 4, animation frames stored (>=1)
TICKS_PER_FRAME, 8, vsync ticks each frame is shown (>=1)
REL_W, 11, width of signed sprite-relative coordinates
TRANSPARENT_IDX, 0, palette index treated as transparent
INIT_FILE, "./sprite/sprite.mif", memory init file (synthesis ram_init_file)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high
vsync_tick  in  1  one-cycle pulse per video frame
anim_en  in  1  1 = animation advances on vsync_tick; 0 = hold frame
anim_restart  in  1  force frame 0, tick count 0
flip_h  in  1  1 = mirror sprite horizontally (facing left)
req_valid  in  1  pixel lookup request this cycle
rel_x  in  REL_W  signed pixel x minus sprite x
rel_y  in  REL_W  signed pixel y minus sprite y
pix_valid  out  1  response valid
pix_idx  out  DATA_W  palette index
pix_opaque  out  1  1 = draw pixel; 0 = transparent or out of bounds
cur_frame  out  clog2(NUM_FRAMES) (min 1)  current animation frame

Behaviour:
- Reset (synchronous, priority over everything): cur_frame=0, tick counter=0, pipeline valids=0, pix_valid=0, pix_idx=0, pix_opaque=0. Memory contents are not reset. Requests in flight when reset asserts are dropped; no pix_valid is produced for them.
- Animation sequencer:
  - Priority: reset > anim_restart > tick.
  - anim_restart=1: frame=0, tick count=0, regardless of vsync_tick or anim_en.
  - Else if anim_en && vsync_tick: if count==TICKS_PER_FRAME-1 then count=0 and frame advances; otherwise count++.
  - Frame advance wraps NUM_FRAMES-1 -> 0.
  - anim_en=0: count and frame hold. vsync_tick has no effect.
  - NUM_FRAMES=1: frame stays 0. TICKS_PER_FRAME=1: frame advances on every enabled tick.
- Lookup pipeline: fixed 2-cycle latency, fully pipelined, one request accepted per cycle, no backpressure.
  - Stage 1 (edge after req_valid):
    - in_bounds = 0<=rel_x<SPR_W && 0<=rel_y<SPR_H, using a signed compare.
    - x' = flip_h ? SPR_W-1-rel_x : rel_x.
    - addr = frame*SPR_W*SPR_H + rel_y*SPR_W + x', where frame is cur_frame sampled in the request cycle, before any same-cycle advance.
    - addr width = clog2(NUM_FRAMES*SPR_W*SPR_H). Out-of-bounds requests load addr 0 to avoid wild reads.
    - Register addr, in_bounds and valid.
  - Stage 2: registered memory read q <= mem[addr]. Pipeline valid and in_bounds with it.
  - Output:
    - pix_valid = stage-2 valid.
    - If in_bounds: pix_idx=q and pix_opaque=(q!=TRANSPARENT_IDX).
    - Else: pix_idx=TRANSPARENT_IDX and pix_opaque=0.
    - When pix_valid=0: pix_idx and pix_opaque hold their previous values. Consumers must qualify with pix_valid.
- Simultaneous frame advance and request: the request uses the pre-advance frame. The next request uses the new frame.
- Memory depth is NUM_FRAMES*SPR_W*SPR_H words of DATA_W bits, single read port, inferred as block RAM.

Test Plan:
1. Reset, then req_valid=1 at rel=(0,0) with frame 0, mem[0]=5 -> pix_valid=1 exactly 2 cycles later, pix_idx=5, pix_opaque=1. pix_valid=0 on the other cycles.
2. Defaults; rel=(3,2), flip_h=0 vs flip_h=1 -> addresses 67 and 92 (2*32+28), returning the respective mem values. rel=(-1,0), (32,0) and (0,32) -> pix_idx=0, pix_opaque=0, pix_valid=1.
3. anim_en=1 with 8 vsync_ticks -> cur_frame 0->1 on the edge of the 8th tick. 32 ticks -> wraps back to 0. Toggle anim_en=0 mid-count -> count and frame frozen.
4. anim_restart asserted together with vsync_tick while frame=2, count=7 -> frame=0, count=0. A request in that cycle reads frame-2 data (addr base 2048).
5. Back-to-back requests on 4 consecutive cycles with distinct coordinates -> 4 consecutive pix_valid cycles in order. Assert reset after the 2nd request -> no pix_valid for requests 2-4, outputs 0, frame 0.
6. Entry equal to TRANSPARENT_IDX in bounds -> pix_opaque=0. With TRANSPARENT_IDX=7 and DATA_W=3, the same word 0 -> pix_opaque=1.
